ro_freq_meter: RTL and testbench

//  Receive-side companion of the gated ring oscillator: drives the ring's enable, samples its

---
 rtl/ro_pkg.sv | 19 +
 rtl/sync_2ff.sv | 23 ++
 rtl/ro_freq_meter.sv | 129 ++++++++++++
 tb/tb_ro_freq_meter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ro_pkg.sv
// rtl/ro_pkg.sv - shared ring-oscillator measurement types and constants
package ro_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } ro_state_t;

    localparam int RO_CNT_W         = 16;
    localparam int RO_WIN_W         = 16;
    localparam int RO_SETTLE_CYCLES = 8;

    function automatic int ro_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser with synchronous clear
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ro_freq_meter.sv
// rtl/ro_freq_meter.sv - gated ring oscillator edge counter over a programmed clk window
module ro_freq_meter
    import ro_pkg::*;
#(
    parameter int CNT_W         = RO_CNT_W,
    parameter int WIN_W         = RO_WIN_W,
    parameter int SETTLE_CYCLES = RO_SETTLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIN_W-1:0] window,
    input  logic             osc_in,
    output logic             osc_enable,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             count_valid,
    input  logic             count_ready
);

    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int DCNT_W = ro_max(WIN_W, SET_W);

    localparam logic [DCNT_W-1:0] SETTLE_LOAD = DCNT_W'(SETTLE_CYCLES);
    localparam logic [DCNT_W-1:0] DCNT_ONE    = DCNT_W'(1);
    localparam logic [CNT_W-1:0]  COUNT_MAX   = '1;

    ro_state_t         state;
    logic [DCNT_W-1:0] dcnt;
    logic [WIN_W-1:0]  win_q;
    logic [WIN_W-1:0]  win_eff;
    logic              accept;
    logic              sync_clr;
    logic              osc_sync;
    logic              osc_prev;
    logic              rise;

    assign accept   = start && (state == ST_IDLE) && !count_valid;
    assign win_eff  = (window == '0) ? WIN_W'(1) : window;
    // Flushing the edge pipeline on accept keeps edges from a previous run out of this one.
    assign sync_clr = rst | accept;

    sync_2ff #(.W(1)) u_osc_sync (
        .clk (clk),
        .rst (sync_clr),
        .d   (osc_in),
        .q   (osc_sync)
    );

    always_ff @(posedge clk) begin
        if (sync_clr) begin
            osc_prev <= 1'b0;
        end else begin
            osc_prev <= osc_sync;
        end
    end

    assign rise = osc_sync & ~osc_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            osc_enable  <= 1'b0;
            busy        <= 1'b0;
            count       <= '0;
            overflow    <= 1'b0;
            count_valid <= 1'b0;
            dcnt        <= '0;
            win_q       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        win_q      <= win_eff;
                        count      <= '0;
                        overflow   <= 1'b0;
                        osc_enable <= 1'b1;
                        busy       <= 1'b1;
                        if (SETTLE_CYCLES == 0) begin
                            dcnt  <= DCNT_W'(win_eff);
                            state <= ST_MEASURE;
                        end else begin
                            dcnt  <= SETTLE_LOAD;
                            state <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (dcnt == DCNT_ONE) begin
                        dcnt  <= DCNT_W'(win_q);
                        state <= ST_MEASURE;
                    end else begin
                        dcnt <= dcnt - DCNT_ONE;
                    end
                end
                ST_MEASURE: begin
                    if (rise) begin
                        if (count == COUNT_MAX) begin
                            overflow <= 1'b1;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                    if (dcnt == DCNT_ONE) begin
                        state <= ST_DONE;
                    end else begin
                        dcnt <= dcnt - DCNT_ONE;
                    end
                end
                ST_DONE: begin
                    // First DONE cycle publishes the result once the final MEASURE edge has landed.
                    if (!count_valid) begin
                        count_valid <= 1'b1;
                        busy        <= 1'b0;
                        osc_enable  <= 1'b0;
                    end else if (count_ready) begin
                        count_valid <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ro_freq_meter.sv
// tb/tb_ro_freq_meter.sv - directed self-checking bench for ro_freq_meter
module tb_ro_freq_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        osc_in;

    logic        start_a, ready_a;
    logic [15:0] window_a;
    logic        osc_en_a, busy_a, ovf_a, valid_a;
    logic [15:0] count_a;

    logic        start_b, ready_b;
    logic [15:0] window_b;
    logic        osc_en_b, busy_b, ovf_b, valid_b;
    logic [3:0]  count_b;

    int checks   = 0;
    int failures = 0;
    int osc_half = 0;

    always #5 clk = ~clk;

    ro_freq_meter #(.CNT_W(16), .WIN_W(16), .SETTLE_CYCLES(8)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .start       (start_a),
        .window      (window_a),
        .osc_in      (osc_in),
        .osc_enable  (osc_en_a),
        .busy        (busy_a),
        .count       (count_a),
        .overflow    (ovf_a),
        .count_valid (valid_a),
        .count_ready (ready_a)
    );

    ro_freq_meter #(.CNT_W(4), .WIN_W(16), .SETTLE_CYCLES(8)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .start       (start_b),
        .window      (window_b),
        .osc_in      (osc_in),
        .osc_enable  (osc_en_b),
        .busy        (busy_b),
        .count       (count_b),
        .overflow    (ovf_b),
        .count_valid (valid_b),
        .count_ready (ready_b)
    );

    // Oscillator model: toggles every osc_half clk cycles, held low when osc_half is 0.
    initial begin
        int ph;
        ph     = 0;
        osc_in = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (osc_half == 0) begin
                osc_in = 1'b0;
                ph     = 0;
            end else begin
                ph++;
                if (ph >= osc_half) begin
                    ph     = 0;
                    osc_in = ~osc_in;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        osc_half = 3;
        repeat (3) tick();
        checks++; if (osc_en_a !== 1'b0) begin failures++; $display("FAIL reset_osc_enable: got %b expected 0", osc_en_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        checks++; if (count_a !== 16'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", count_a); end
        checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", ovf_a); end
        checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", valid_a); end
        checks++; if (osc_en_b !== 1'b0 || valid_b !== 1'b0) begin failures++; $display("FAIL reset_b: osc_en=%b valid=%b expected 0 0", osc_en_b, valid_b); end
        rst = 1'b0;
        repeat (4) tick();
        checks++; if (valid_a !== 1'b0 || osc_en_a !== 1'b0) begin failures++; $display("FAIL post_reset_idle: valid=%b osc_en=%b expected 0 0", valid_a, osc_en_a); end
    endtask

    task automatic test_basic();
        int lat;
        osc_half = 5;
        window_a = 16'd100;
        ready_a  = 1'b0;
        start_a  = 1'b1;
        tick();
        start_a  = 1'b0;
        checks++; if (busy_a !== 1'b1 || osc_en_a !== 1'b1) begin failures++; $display("FAIL basic_accept: busy=%b osc_en=%b expected 1 1", busy_a, osc_en_a); end
        lat = 0;
        while (valid_a !== 1'b1 && lat < 400) begin
            tick();
            lat++;
        end
        checks++; if (lat !== 109) begin failures++; $display("FAIL basic_latency: got %0d expected 109", lat); end
        checks++; if (count_a < 16'd9 || count_a > 16'd11) begin failures++; $display("FAIL basic_count: got %0d expected 10 +/-1", count_a); end
        checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL basic_overflow: got %b expected 0", ovf_a); end
        checks++; if (osc_en_a !== 1'b0 || busy_a !== 1'b0) begin failures++; $display("FAIL basic_done_outputs: osc_en=%b busy=%b expected 0 0", osc_en_a, busy_a); end
    endtask

    task automatic test_handshake();
        logic [15:0] held;
        int          lat;
        held = count_a;
        ready_a = 1'b0;
        for (int i = 0; i < 20; i++) begin
            start_a = (i % 3 == 0);
            tick();
            checks++;
            if (valid_a !== 1'b1 || busy_a !== 1'b0 || count_a !== held || ovf_a !== 1'b0) begin
                failures++;
                $display("FAIL hold_cycle_%0d: valid=%b busy=%b count=%0d ovf=%b expected 1 0 %0d 0", i, valid_a, busy_a, count_a, ovf_a, held);
            end
        end
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        ready_a = 1'b0;
        start_a = 1'b0;
        checks++; if (valid_a !== 1'b0 || busy_a !== 1'b0) begin failures++; $display("FAIL handoff_start_ignored: valid=%b busy=%b expected 0 0", valid_a, busy_a); end
        osc_half = 0;
        window_a = 16'd0;
        start_a  = 1'b1;
        tick();
        start_a  = 1'b0;
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL restart_accept: busy=%b expected 1", busy_a); end
        lat = 0;
        while (valid_a !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        checks++; if (lat !== 10) begin failures++; $display("FAIL window0_latency: got %0d expected 10", lat); end
        checks++; if (count_a !== 16'd0 || ovf_a !== 1'b0) begin failures++; $display("FAIL window0_count: count=%0d ovf=%b expected 0 0", count_a, ovf_a); end
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL window0_release: valid=%b expected 0", valid_a); end
    endtask

    task automatic test_saturation();
        int lat;
        osc_half = 2;
        window_b = 16'd200;
        ready_b  = 1'b0;
        start_b  = 1'b1;
        tick();
        start_b  = 1'b0;
        lat = 0;
        while (valid_b !== 1'b1 && lat < 400) begin
            tick();
            lat++;
        end
        checks++; if (lat !== 209) begin failures++; $display("FAIL sat_latency: got %0d expected 209", lat); end
        checks++; if (count_b !== 4'd15) begin failures++; $display("FAIL sat_count: got %0d expected 15", count_b); end
        checks++; if (ovf_b !== 1'b1) begin failures++; $display("FAIL sat_overflow: got %b expected 1", ovf_b); end
        ready_b = 1'b1;
        tick();
        ready_b = 1'b0;
        checks++; if (valid_b !== 1'b0) begin failures++; $display("FAIL sat_release: valid=%b expected 0", valid_b); end
    endtask

    task automatic test_reset_mid();
        int seen;
        osc_half = 5;
        window_a = 16'd100;
        start_a  = 1'b1;
        tick();
        start_a  = 1'b0;
        repeat (8 + 50) tick();
        checks++; if (busy_a !== 1'b1 || osc_en_a !== 1'b1) begin failures++; $display("FAIL mid_running: busy=%b osc_en=%b expected 1 1", busy_a, osc_en_a); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (osc_en_a !== 1'b0 || busy_a !== 1'b0) begin failures++; $display("FAIL mid_reset_outputs: osc_en=%b busy=%b expected 0 0", osc_en_a, busy_a); end
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (valid_a === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL mid_no_result: valid seen %0d cycles expected 0", seen); end
    endtask

    initial begin
        rst      = 1'b1;
        start_a  = 1'b0;
        ready_a  = 1'b0;
        window_a = 16'd0;
        start_b  = 1'b0;
        ready_b  = 1'b0;
        window_b = 16'd0;
        test_reset();
        test_basic();
        test_handshake();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
